// File: rtl/cpu_types_pkg.sv
// Shared types for the multicore memory system: RAM status, data words,
// and the arbiter state/request encodings.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_type_t;

endpackage

// File: rtl/memory_arbiter_pick.sv
// Combinational round-robin picker: scans cores upward from rr (wrapping)
// and returns the first requester; dcache beats icache within a core.
module memory_arbiter_pick
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  parameter int CW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CW-1:0]   rr,
  input  logic [CPUS-1:0] iREN,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  output logic            valid,
  output logic [CW-1:0]   core,
  output req_type_t       rtype
);

  int idx;

  always_comb begin
    valid = 1'b0;
    core  = '0;
    rtype = REQ_I;
    idx   = 0;
    for (int k = 0; k < CPUS; k++) begin
      idx = (int'(rr) + k) % CPUS;
      if (!valid && (dREN[idx] || dWEN[idx] || iREN[idx])) begin
        valid = 1'b1;
        core  = idx[CW-1:0];
        rtype = (dREN[idx] || dWEN[idx]) ? REQ_D : REQ_I;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates per-core icache/dcache miss traffic onto the single RAM port,
// holding one grant until RAM reports ACCESS and rotating between cores.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0][31:0] iload,
  output logic [CPUS-1:0][31:0] dload,
  input  logic [1:0]           ramstate,
  input  logic [31:0]          ramload,
  output logic                 memREN,
  output logic                 memWEN,
  output logic [31:0]          memaddr,
  output logic [31:0]          memstore
);

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t      state, state_n;
  req_type_t       otype, otype_n;
  logic [CW-1:0]   owner, owner_n;
  logic [CW-1:0]   rr, rr_n;

  logic            pick_valid;
  logic [CW-1:0]   pick_core;
  req_type_t       pick_type;

  ramstate_t       rs;
  logic            oreq;
  logic            done;

  assign rs = ramstate_t'(ramstate);

  memory_arbiter_pick #(
    .CPUS (CPUS),
    .CW   (CW)
  ) u_pick (
    .rr    (rr),
    .iREN  (iREN),
    .dREN  (dREN),
    .dWEN  (dWEN),
    .valid (pick_valid),
    .core  (pick_core),
    .rtype (pick_type)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= '0;
      otype <= REQ_I;
      rr    <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      otype <= otype_n;
      rr    <= rr_n;
    end
  end

  // The owner's request as currently presented; dropping it aborts the grant.
  always_comb begin
    oreq = (otype == REQ_D) ? (dREN[owner] | dWEN[owner]) : iREN[owner];
    done = (state == GRANT) && oreq && (rs == ACCESS);
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    otype_n = otype;
    rr_n    = rr;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = GRANT;
          owner_n = pick_core;
          otype_n = pick_type;
        end
      end
      GRANT: begin
        if (done) begin
          state_n = IDLE;
          rr_n    = (owner == CW'(CPUS - 1)) ? '0 : owner + 1'b1;
        end else if (!oreq) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM port follows the owner's inputs live; BUSY/ERROR simply keep it driven.
  always_comb begin
    memREN   = 1'b0;
    memWEN   = 1'b0;
    memaddr  = '0;
    memstore = '0;
    if (state == GRANT) begin
      if (otype == REQ_D) begin
        memWEN   = dWEN[owner];
        memREN   = dREN[owner] & ~dWEN[owner];
        memaddr  = daddr[owner];
        memstore = dstore[owner];
      end else begin
        memREN   = iREN[owner];
        memaddr  = iaddr[owner];
      end
    end
  end

  always_comb begin
    iwait = '0;
    dwait = '0;
    iload = '0;
    dload = '0;
    for (int c = 0; c < CPUS; c++) begin
      iwait[c] = iREN[c] & ~(done && (owner == c[CW-1:0]) && (otype == REQ_I));
      dwait[c] = (dREN[c] | dWEN[c]) &
                 ~(done && (owner == c[CW-1:0]) && (otype == REQ_D));
      iload[c] = ramload;
      dload[c] = ramload;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with two cores and hand-computed expectations.
module tb_memory_arbiter;

  localparam int CPUS = 2;

  logic                  CLK;
  logic                  nRST;
  logic [CPUS-1:0]       iREN, dREN, dWEN;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]       iwait, dwait;
  logic [CPUS-1:0][31:0] iload, dload;
  logic [1:0]            ramstate;
  logic [31:0]           ramload;
  logic                  memREN, memWEN;
  logic [31:0]           memaddr, memstore;

  int checks = 0;
  int failures = 0;

  memory_arbiter #(.CPUS(CPUS)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramstate (ramstate),
    .ramload  (ramload),
    .memREN   (memREN),
    .memWEN   (memWEN),
    .memaddr  (memaddr),
    .memstore (memstore)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACC = 2'd2, R_ERR = 2'd3;

  initial begin
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramstate = R_FREE; ramload = '0;

    // Reset state: wait mirrors request, RAM port idle
    iREN = 2'b01; iaddr[0] = 32'h40;
    #1;
    chk("rst_memREN", memREN, 0);
    chk("rst_memWEN", memWEN, 0);
    chk("rst_memaddr", memaddr, 0);
    chk("rst_memstore", memstore, 0);
    chk("rst_iwait", iwait, 2'b01);
    tick(); tick();
    nRST = 1'b1; #1;

    // T1: core0 icache read, ACCESS two cycles after grant
    chk("t1_c0_idle_memREN", memREN, 0);
    chk("t1_c0_iwait", iwait, 2'b01);
    tick();
    ramstate = R_BUSY; #1;
    chk("t1_c1_memREN", memREN, 1);
    chk("t1_c1_memaddr", memaddr, 32'h40);
    chk("t1_c1_memstore", memstore, 0);
    chk("t1_c1_iwait", iwait, 2'b01);
    tick();
    chk("t1_c2_iwait", iwait, 2'b01);
    tick();
    ramstate = R_ACC; ramload = 32'hDEADBEEF; #1;
    chk("t1_c3_iwait", iwait, 2'b00);
    chk("t1_c3_iload", iload[0], 32'hDEADBEEF);
    tick();
    ramstate = R_FREE; #1;
    chk("t1_c4_iwait", iwait, 2'b01);
    chk("t1_c4_memREN", memREN, 0);
    iREN = 2'b00;
    tick();

    // T2: both cores dREN right after reset, core0 first
    nRST = 1'b0; #1; nRST = 1'b1;
    dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h104; #1;
    chk("t2_idle_dwait", dwait, 2'b11);
    tick();
    ramstate = R_ACC; ramload = 32'h11111111; #1;
    chk("t2_g0_memaddr", memaddr, 32'h100);
    chk("t2_g0_memREN", memREN, 1);
    chk("t2_g0_memWEN", memWEN, 0);
    chk("t2_g0_dwait", dwait, 2'b10);
    chk("t2_g0_dload", dload[0], 32'h11111111);
    tick();
    dREN = 2'b10; ramstate = R_FREE; #1;
    chk("t2_bubble_memREN", memREN, 0);
    chk("t2_bubble_dwait", dwait, 2'b10);
    tick();
    ramstate = R_ACC; #1;
    chk("t2_g1_memaddr", memaddr, 32'h104);
    chk("t2_g1_dwait", dwait, 2'b00);
    tick();
    dREN = 2'b00; ramstate = R_FREE;

    // T3: core1 dcache write (with dREN) beats its icache read
    iREN = 2'b10; iaddr[1] = 32'h300;
    dWEN = 2'b10; dREN = 2'b10; daddr[1] = 32'h200; dstore[1] = 32'h12345678; #1;
    tick();
    ramstate = R_ACC; #1;
    chk("t3_w_memWEN", memWEN, 1);
    chk("t3_w_memREN", memREN, 0);
    chk("t3_w_memaddr", memaddr, 32'h200);
    chk("t3_w_memstore", memstore, 32'h12345678);
    chk("t3_w_dwait", dwait, 2'b00);
    chk("t3_w_iwait", iwait, 2'b10);
    tick();
    dWEN = 2'b00; dREN = 2'b00; ramstate = R_FREE; #1;
    chk("t3_bubble_memWEN", memWEN, 0);
    tick();
    ramstate = R_ACC; ramload = 32'hCAFEF00D; #1;
    chk("t3_i_memREN", memREN, 1);
    chk("t3_i_memaddr", memaddr, 32'h300);
    chk("t3_i_memstore", memstore, 0);
    chk("t3_i_iwait", iwait, 2'b00);
    chk("t3_i_iload", iload[1], 32'hCAFEF00D);
    tick();
    iREN = 2'b00; ramstate = R_FREE;

    // T4: ERROR for three cycles then ACCESS
    dREN = 2'b01; daddr[0] = 32'h500; #1;
    tick();
    ramstate = R_ERR; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_err_memaddr", memaddr, 32'h500);
      chk("t4_err_memREN", memREN, 1);
      chk("t4_err_dwait", dwait, 2'b01);
      tick();
    end
    ramstate = R_ACC; #1;
    chk("t4_acc_dwait", dwait, 2'b00);
    tick();
    dREN = 2'b00; ramstate = R_FREE; #1;
    chk("t4_after_memREN", memREN, 0);

    // T5: core1 aborts under BUSY; rr stays at 1
    dREN = 2'b10; daddr[1] = 32'h600; #1;
    tick();
    ramstate = R_BUSY; #1;
    chk("t5_g_memREN", memREN, 1);
    chk("t5_g_memaddr", memaddr, 32'h600);
    dREN = 2'b00; #1;
    chk("t5_drop_dwait", dwait, 2'b00);
    tick();
    chk("t5_idle_memREN", memREN, 0);
    chk("t5_idle_dwait", dwait, 2'b00);
    iREN = 2'b11; #1;
    tick();
    chk("t5_rr_memaddr", memaddr, 32'h300);

    // T6: reset during GRANT drops the port at once, then core0 wins
    nRST = 1'b0; #1;
    chk("t6_rst_memREN", memREN, 0);
    chk("t6_rst_memWEN", memWEN, 0);
    chk("t6_rst_memaddr", memaddr, 0);
    chk("t6_rst_iwait", iwait, 2'b11);
    nRST = 1'b1;
    tick();
    ramstate = R_ACC; #1;
    chk("t6_regrant_memaddr", memaddr, 32'h40);
    chk("t6_regrant_iwait", iwait, 2'b10);
    tick();
    iREN = 2'b00; ramstate = R_FREE;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Arbitrates the instruction- and data-cache miss traffic of every core onto the single RAM port of the system. It sits directly upstream of the RAM port and downstream of the per-core caches in the multicore build. It drives the processor-side memory request signals, which the system top then steers to RAM when the testbench does not own the RAM port. It registers one grant at a time, holds it until RAM reports ACCESS, and rotates fairly between cores.

## Interface
Parameters:
- CPUS, 2, number of cores; each core has one icache port and one dcache port.

Ports (vectors are indexed by core number, 0..CPUS-1):
- Clocking and reset: one clock, CLK; reset is asynchronous and active-low, nRST.
- CLK  in  1  system clock, same clock as RAM.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  CPUS  icache read request, held until its wait drops.
- iaddr  in  CPUS x 32  icache word address.
- dREN  in  CPUS  dcache read request.
- dWEN  in  CPUS  dcache write request.
- daddr  in  CPUS x 32  dcache word address.
- dstore  in  CPUS x 32  dcache write data.
- iwait  out  CPUS  icache stall; low for exactly the completing cycle.
- dwait  out  CPUS  dcache stall; low for exactly the completing cycle.
- iload  out  CPUS x 32  read data, equal to ramload; valid when iwait is low.
- dload  out  CPUS x 32  read data, equal to ramload; valid when dwait is low.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- ramload  in  32  RAM read data.
- memREN  out  1  RAM read enable.
- memWEN  out  1  RAM write enable.
- memaddr  out  32  RAM address.
- memstore  out  32  RAM write data.

## Operation
- FSM states: IDLE and GRANT. Registered state: owner core, owner type (I or D), and the round-robin pointer `rr`.
- IDLE:
  - If any request is present, register an owner and go to GRANT.
  - Core selection starts at `rr` and scans upward, wrapping modulo CPUS; the first core with a request wins.
  - Within a core, a dcache request (dREN or dWEN) beats an icache request.
- GRANT:
  - Drive the RAM port combinationally from the owner's inputs.
  - memWEN = owner dWEN. memREN = owner read and not dWEN; write wins if dREN and dWEN are both high.
  - memaddr and memstore are the owner's address and store data. memstore is 0 for icache owners.
- Completion: if ramstate==ACCESS while the owner's request is still high:
  - the owner's wait is low for that cycle;
  - the next state is IDLE;
  - rr becomes (owner+1) mod CPUS.
- Abort: if the owner drops its request while in GRANT, return to IDLE next cycle with no wait-low pulse. rr is unchanged.
- ERROR and BUSY: keep the grant and keep driving the RAM port; the access is retried until ACCESS arrives.
- Wait generation: wait = request & ~(owner match & ACCESS & GRANT). A requester with no request sees wait low.
- Outside GRANT: memREN, memWEN, memaddr and memstore are all 0.

## Timing
- Reset values: state=IDLE, rr=0, owner=core0/I. memREN, memWEN, memaddr and memstore are 0. The wait outputs equal their request inputs.
- Reset mid-access drops the RAM request in the same cycle, asynchronously. No completion is signalled.
- Latency:
  - Request seen at cycle 0; grant at edge 1; RAM port driven from cycle 1.
  - Completion happens in the first GRANT cycle where ramstate==ACCESS.
  - Minimum latency is 2 cycles with zero-latency RAM.
- Back-to-back: at least one IDLE bubble between grants.
- Starvation bound: with continuous contention, each core is served within CPUS grants.
- Simultaneous events: a new request arriving in a completion cycle is evaluated in the following IDLE cycle, using the updated rr.

## Structure
- cpu_types_pkg holds:
  - ramstate_t and word_t (existing);
  - new arb_state_t {IDLE, GRANT};
  - new req_type_t {REQ_I, REQ_D}.
- Sub-module memory_arbiter_pick: combinational round-robin picker.
  - Inputs: rr and the per-core request vectors.
  - Outputs: winning core and type.
- Everything else lives in memory_arbiter: the FSM, output muxing and wait logic.

## Test plan
- Core0 iREN, iaddr=0x40; RAM gives ACCESS 2 cycles after the grant, ramload=0xDEADBEEF -> memREN high from cycle 1, memaddr=0x40, iwait0 low on exactly one cycle, iload0=0xDEADBEEF.
- Core0 and core1 both assert dREN at cycle 0 after reset -> core0 is served first; core1 is granted in the IDLE cycle after core0 completes.
- Core1 asserts iREN and dWEN together, daddr=0x200, dstore=0x12345678 -> the dcache write is served first with memWEN=1 and memstore=0x12345678; the icache read is served after it.
- ramstate=ERROR for 3 cycles, then ACCESS -> the grant and memaddr are stable throughout; exactly one dwait-low pulse.
- Owner drops dREN while ramstate=BUSY -> memREN=0 the next cycle, no wait pulse, rr unchanged.
- nRST asserted in GRANT -> memREN and memWEN drop immediately; after reset, the pending request is re-arbitrated starting from core0.
